period_meter: RTL and testbench

//   Measures the period of an external square wave in system-clock cycles; the receive-side

---
 rtl/period_meter.sv | 144 ++++++++++++++
 tb/tb_period_meter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// ---------------------------------------------------------------------------
// period_meter
//   Measures the period of an external square wave in system-clock cycles.
//   signalIn is synchronised, rising edges are detected, and the number of
//   clock cycles between consecutive rising edges is presented on a
//   valid/ready output. A sticky timeout flags a missing edge, and a sticky
//   overrun flags a dropped result.
//
// Ports
//   clock        in   1      system clock, rising edge
//   reset        in   1      asynchronous, active-high; clears all state
//   enable       in   1      1 = measure, 0 = return to IDLE (partial count lost)
//   signalIn     in   1      asynchronous signal under measurement
//   periodValue  out  WIDTH  last measured period in clock cycles
//   periodValid  out  1      periodValue holds an unconsumed result
//   periodReady  in   1      consumer accepts when periodValid & periodReady
//   timeout      out  1      sticky: no edge within TIMEOUT_CYCLES; cleared by next capture
//   overrun      out  1      sticky: a result was dropped; cleared only by reset
//   debugState   out  2      current FSM state (IDLE/ARM/MEASURE)
//
// Handshake: a result is transferred on every clock edge where periodValid
//   and periodReady are both 1. periodValid, once raised, stays high and
//   periodValue stays stable until that transfer; periodReady may change
//   freely and has no combinational path to any output.
// ---------------------------------------------------------------------------
module period_meter #(
    parameter int unsigned      WIDTH          = 32,
    parameter logic [WIDTH-1:0] TIMEOUT_CYCLES = WIDTH'(1000000),
    parameter int unsigned      SYNC_STAGES    = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             signalIn,
    output logic [WIDTH-1:0] periodValue,
    output logic             periodValid,
    input  logic             periodReady,
    output logic             timeout,
    output logic             overrun,
    output logic [1:0]       debugState
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   history;
    logic                   edge_det;
    logic [1:0]             state;
    logic [WIDTH-1:0]       counter;
    logic                   capture;
    logic                   accept;
    logic                   timeout_hit;

    // Synchroniser chain plus one history flop for rising-edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            history <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], signalIn};
            history <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        edge_det    = sync_q[SYNC_STAGES-1] & ~history;
        capture     = enable && (state == ST_MEASURE) && edge_det;
        // An edge in the same cycle as the timeout count wins over the timeout.
        timeout_hit = enable && (state == ST_MEASURE) && !edge_det &&
                      (counter == TIMEOUT_CYCLES);
        // A fresh result can be taken if the slot is empty or being drained now.
        accept      = !periodValid || periodReady;
    end

    // Measurement FSM. counter holds the cycles since the last accepted edge,
    // so it reads P exactly when an edge P cycles after the previous one lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            counter <= '0;
        end else if (!enable) begin
            state   <= ST_IDLE;
            counter <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    counter <= '0;
                    state   <= ST_ARM;
                end
                ST_ARM: begin
                    if (edge_det) begin
                        counter <= WIDTH'(1);
                        state   <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (edge_det) begin
                        counter <= WIDTH'(1);
                    end else if (counter == TIMEOUT_CYCLES) begin
                        counter <= '0;
                        state   <= ST_ARM;
                    end else begin
                        counter <= counter + WIDTH'(1);
                    end
                end
                default: begin
                    counter <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Result register and status flags. These run independently of enable so
    // a pending result survives a stop and is still drained by the consumer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            periodValue <= '0;
            periodValid <= 1'b0;
            timeout     <= 1'b0;
            overrun     <= 1'b0;
        end else if (capture) begin
            if (accept) begin
                periodValue <= counter;
                periodValid <= 1'b1;
                timeout     <= 1'b0;
            end else begin
                overrun     <= 1'b1;
            end
        end else begin
            if (periodValid && periodReady) begin
                periodValid <= 1'b0;
            end
            if (timeout_hit) begin
                timeout <= 1'b1;
            end
        end
    end

    assign debugState = state;

endmodule

// File: tb/tb_period_meter.sv
module tb_period_meter;

    localparam int SYNC = 2;
    localparam int TO   = 50;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        signalIn = 1'b0;
    logic        periodReady = 1'b0;
    logic [31:0] periodValue;
    logic        periodValid;
    logic        timeout;
    logic        overrun;
    logic [1:0]  debugState;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    // waveform generator controls: 0 = manual, 1 = square wave, 2 = random
    int gen_mode = 0;
    int gen_period = 10;
    int phase = 0;

    period_meter #(
        .WIDTH(32),
        .TIMEOUT_CYCLES(32'd50),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .signalIn(signalIn),
        .periodValue(periodValue),
        .periodValid(periodValid),
        .periodReady(periodReady),
        .timeout(timeout),
        .overrun(overrun),
        .debugState(debugState)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        #2 reset = 1'b0;
    endtask

    // ---------------- stimulus generator ----------------
    always @(negedge clock) begin
        if (gen_mode == 1) begin
            phase = (phase + 1 >= gen_period) ? 0 : phase + 1;
            signalIn = (phase < (gen_period + 1) / 2);
        end else if (gen_mode == 2) begin
            if ($urandom_range(0, 3) == 0) signalIn = ~signalIn;
        end
    end

    task automatic start_wave(input int p);
        gen_mode = 0;
        signalIn = 1'b0;
        repeat (3) @(negedge clock);
        do_reset();
        gen_period = p;
        phase = p - 1;
        gen_mode = 1;
    endtask

    // ---------------- reference model ----------------
    // Works on timestamps of detected edges rather than a running counter.
    // A rising edge of signalIn sampled at clock n-SYNC is acted upon at clock n.
    bit          hist[$];
    int          n_clk;
    int          last_t;
    int          mode;        // 0 stopped, 1 waiting first edge, 2 measuring
    logic [31:0] m_value;
    bit          m_valid, m_timeout, m_overrun;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            hist.delete();
            for (int i = 0; i <= SYNC; i++) hist.push_back(1'b0);
            n_clk = 0; last_t = 0; mode = 0;
            m_value = '0; m_valid = 0; m_timeout = 0; m_overrun = 0;
        end else begin
            bit ev;
            bit cap;
            int per;
            n_clk++;
            ev  = hist[SYNC-1] && !hist[SYNC];
            cap = 0;
            per = 0;
            if (!enable) mode = 0;
            else if (mode == 0) mode = 1;
            else if (mode == 1) begin
                if (ev) begin mode = 2; last_t = n_clk; end
            end else begin
                if (ev) begin
                    cap = 1; per = n_clk - last_t; last_t = n_clk;
                end else if (n_clk - last_t == TO) begin
                    m_timeout = 1; mode = 1;
                end
            end
            if (cap) begin
                if (!m_valid || periodReady) begin
                    m_value = 32'(per); m_valid = 1; m_timeout = 0;
                end else begin
                    m_overrun = 1;
                end
            end else if (m_valid && periodReady) begin
                m_valid = 0;
            end
            hist.push_front(signalIn);
            void'(hist.pop_back());
        end
    end

    // ---------------- scoreboard ----------------
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (checking) begin
            cmp("model periodValue", periodValue, m_value);
            cmp("model periodValid", 32'(periodValid), 32'(m_valid));
            cmp("model timeout", 32'(timeout), 32'(m_timeout));
            cmp("model overrun", 32'(overrun), 32'(m_overrun));
        end
    end

    task automatic wait_valid(input int budget, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (periodValid) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: got no periodValid expected one within %0d cycles", name, budget);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        cmp("reset periodValue", periodValue, 32'd0);
        cmp("reset periodValid", 32'(periodValid), 32'd0);
        cmp("reset timeout", 32'(timeout), 32'd0);
        cmp("reset overrun", 32'(overrun), 32'd0);
        checking = 1'b1;

        // square wave period 10, consumer always ready
        enable = 1'b1; periodReady = 1'b1;
        start_wave(10);
        wait_valid(40, "p10 valid");
        cmp("p10 value", periodValue, 32'd10);
        repeat (60) @(negedge clock);
        cmp("p10 overrun", 32'(overrun), 32'd0);

        // single edge then silence -> timeout, then period 20 clears it
        start_wave(10);
        gen_mode = 0; signalIn = 1'b0;
        @(negedge clock); signalIn = 1'b1;
        repeat (3) @(negedge clock); signalIn = 1'b0;
        repeat (60) @(negedge clock);
        cmp("timeout set", 32'(timeout), 32'd1);
        cmp("timeout no result", 32'(periodValid), 32'd0);
        gen_period = 20; phase = 19; gen_mode = 1;
        wait_valid(80, "p20 valid");
        cmp("p20 value", periodValue, 32'd20);
        cmp("p20 timeout cleared", 32'(timeout), 32'd0);

        // boundary periods
        start_wave(2);
        wait_valid(20, "p2 valid");
        cmp("p2 value", periodValue, 32'd2);
        start_wave(TO);
        wait_valid(130, "p50 valid");
        cmp("p50 value", periodValue, 32'd50);
        cmp("p50 no timeout", 32'(timeout), 32'd0);
        start_wave(TO + 1);
        repeat (200) @(negedge clock);
        cmp("p51 timeout", 32'(timeout), 32'd1);
        cmp("p51 no result", 32'(periodValid), 32'd0);

        // consumer stalled -> hold and overrun, then drain
        periodReady = 1'b0;
        start_wave(8);
        wait_valid(40, "p8 valid");
        cmp("p8 value", periodValue, 32'd8);
        cmp("p8 overrun clear", 32'(overrun), 32'd0);
        repeat (10) @(negedge clock);
        cmp("p8 overrun set", 32'(overrun), 32'd1);
        cmp("p8 held valid", 32'(periodValid), 32'd1);
        cmp("p8 held value", periodValue, 32'd8);
        periodReady = 1'b1;
        repeat (2) @(negedge clock);
        wait_valid(20, "p8 resume");
        cmp("p8 resume value", periodValue, 32'd8);

        // capture coinciding with a transfer: edges 9 then 6 cycles apart
        periodReady = 1'b0;
        start_wave(8);
        gen_mode = 0; signalIn = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (c == 18) begin
                cmp("coincide valid", 32'(periodValid), 32'd1);
                cmp("coincide value", periodValue, 32'd6);
                cmp("coincide overrun", 32'(overrun), 32'd0);
            end
            signalIn = (c == 0 || c == 1 || c == 9 || c == 10 || c == 15 || c == 16);
            periodReady = (c == 17);
        end

        // reset mid-measurement, period 12
        periodReady = 1'b0;
        start_wave(12);
        wait_valid(50, "p12 valid");
        repeat (28) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        cmp("async reset value", periodValue, 32'd0);
        cmp("async reset valid", 32'(periodValid), 32'd0);
        cmp("async reset overrun", 32'(overrun), 32'd0);
        @(negedge clock);
        #2 reset = 1'b0;
        periodReady = 1'b1;
        wait_valid(60, "p12 restart");
        cmp("p12 restart value", periodValue, 32'd12);

        // enable dropped with a pending result
        periodReady = 1'b0;
        start_wave(8);
        wait_valid(40, "en valid");
        enable = 1'b0;
        repeat (20) @(negedge clock);
        cmp("en held valid", 32'(periodValid), 32'd1);
        cmp("en held value", periodValue, 32'd8);
        enable = 1'b1; periodReady = 1'b1;
        repeat (2) @(negedge clock);
        wait_valid(40, "en restart");
        cmp("en restart value", periodValue, 32'd8);

        // randomized segments
        for (int s = 0; s < 40; s++) begin
            int cyc;
            int rdy;
            if ($urandom_range(0, 9) == 0) do_reset();
            gen_period = $urandom_range(2, 60);
            gen_mode = $urandom_range(1, 2);
            rdy = $urandom_range(0, 4);
            cyc = $urandom_range(30, 150);
            for (int c = 0; c < cyc; c++) begin
                @(negedge clock);
                periodReady = ($urandom_range(0, 3) < rdy);
                enable = ($urandom_range(0, 99) != 0);
            end
        end
        enable = 1'b1;
        repeat (5) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got time limit expected sequence end");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
